rsa_two_power_mod: RTL and testbench
====================================

# rsa_two_power_mod

Precomputation block that produces the Montgomery conversion constant 2^(2·MOD_WIDTH) mod N for a given modulus N. It sits directly upstream of the Montgomery exponentiation core and drives that core's base input. It turns a bare modulus into the base operand the core consumes, so software no longer has to supply it. It uses a bit-serial shift-and-subtract loop with one modular doubling per cycle and valid/ready handshakes on both sides.

## Interface

- MOD_WIDTH, RSA_pkg::MOD_WIDTH (256): modulus width in bits; not overridden locally. KeyType is RSA_pkg::KeyType.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- i_valid  input  1  i_modulus is valid.
- i_ready  output  1  block can accept a modulus.
- i_modulus  input  MOD_WIDTH  modulus N (KeyType).
- o_valid  output  1  o_base holds a finished result.
- o_ready  input  1  downstream accepts o_base.
- o_base  output  MOD_WIDTH  2^(2·MOD_WIDTH) mod N (KeyType).

## Operation

- FSM states: IDLE, CALC, DONE.
- IDLE: i_ready=1, o_valid=0. On i_valid && i_ready:
  - latch N <= i_modulus, r <= 1, cnt <= 0;
  - go to CALC.
- CALC: i_ready=0, o_valid=0. Each cycle:
  - d = {r,1'b0} (MOD_WIDTH+1 bits);
  - r <= (d >= {1'b0,N}) ? d - N : d (result truncated to MOD_WIDTH bits);
  - cnt <= cnt + 1.
  - When cnt == 2·MOD_WIDTH-1 is updated, go to DONE.
- cnt width is $clog2(2·MOD_WIDTH+1). It never wraps in normal operation.
- DONE: o_valid=1, o_base=r, i_ready=0. On o_ready, go to IDLE.
- Invariant: r < N after every CALC step. After 2·MOD_WIDTH steps, r = 2^(2·MOD_WIDTH) mod N.
- Legal input: N odd and N >= 3. Any other N (even, 0, or 1) gives an unspecified o_base value. Timing and handshake behaviour are unchanged for such inputs; no hang, no error flag.
- i_modulus is sampled only on the accept edge. Later changes to i_modulus have no effect.
- o_base is a register output (r).
  - Stable throughout DONE.
  - Holds its last value in IDLE.
  - Changes freely in CALC. Consumers must qualify it with o_valid.

## Timing

- Reset (rst low, asynchronous): state=IDLE, i_ready=1, o_valid=0, o_base=0, cnt=0, N=0.
- Reset asserted mid-CALC or mid-DONE: the job is discarded and the block returns to IDLE immediately. No o_valid pulse follows release.
- Latency: accept edge at cycle T gives o_valid high from cycle T+2·MOD_WIDTH+1, i.e. T+513 at MOD_WIDTH=256.
- Handshake: transfer occurs on a rising edge with valid && ready.
  - o_valid and o_base are held unchanged while o_ready=0, for any number of cycles.
  - o_valid never depends combinationally on o_ready.
- i_ready depends only on state (high only in IDLE). There is no combinational path from any input to any output.
- Throughput: one job per 2·MOD_WIDTH+2 cycles minimum. A new accept is possible on the cycle after the output handshake.
- i_valid while busy is ignored. The upstream must hold i_valid and i_modulus until i_ready.

## Test plan

- Reset values:
  - assert rst low mid-cycle with no clock;
  - check i_ready=1, o_valid=0, o_base=0 immediately;
  - release and idle 10 cycles: o_valid stays 0.
- Known values, MOD_WIDTH=256, o_ready=1:

  | N | expected o_base |
  |---|---|
  | 3 | 1 |
  | 7 | 4 |
  | 11 | 4 |
  | 2^256-1 | 1 |
  | 2^255+1 | 4 |

  Each result appears exactly 513 cycles after accept.
- Backpressure:
  - N=7 with o_ready=0 for 20 cycles after o_valid;
  - check o_valid and o_base=4 stay stable;
  - check i_ready=0 throughout;
  - raise o_ready: handshake occurs, i_ready=1 the next cycle.
- Busy input ignored: during CALC, drive i_valid=1 with N=5. Check the first result is unaffected. The N=5 job is accepted only once the block is back in IDLE, and yields 1.
- Reset mid-operation: pulse rst low at cycle 200 of a CALC. Check no o_valid follows. A subsequent N=11 job returns 4 at full latency.
- Random regression: 1000 random odd N with the MSB set or clear. Compare against a golden model of pow(2,512,N) under random o_ready/i_valid stalls. Then chain the output into the exponentiation core and check msg^key mod N end to end.

Source files
------------

// File: rtl/rsa_two_power_mod.sv
`default_nettype none

// ============================================================================
//  RSA_pkg
//  Shared RSA sizing and operand types.
//  Revision: 1.0 - initial release
// ============================================================================
package RSA_pkg;
   localparam int MOD_WIDTH = 256;
   typedef logic [MOD_WIDTH-1:0] KeyType;
endpackage : RSA_pkg

// ============================================================================
//  rsa_two_power_mod
//  Computes the Montgomery conversion constant 2^(2*MOD_WIDTH) mod N for a
//  modulus N, using one modular doubling per clock (shift-and-subtract).
//  The result feeds the base operand of the Montgomery exponentiation core.
//
//  Ports
//     clk        in   clock, rising edge
//     rst        in   asynchronous reset, active low
//     i_valid    in   i_modulus is valid
//     i_ready    out  block can accept a modulus (high only when idle)
//     i_modulus  in   modulus N (must be odd and >= 3 for a meaningful result)
//     o_valid    out  o_base holds a finished result
//     o_ready    in   downstream accepts o_base
//     o_base     out  2^(2*MOD_WIDTH) mod N, registered
//
//  Revision: 1.0 - initial release
// ============================================================================
module rsa_two_power_mod
   import RSA_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_valid,
   output logic   i_ready,
   input  KeyType i_modulus,
   output logic   o_valid,
   input  logic   o_ready,
   output KeyType o_base
);

   // Number of doublings needed to go from 1 to 2^(2*MOD_WIDTH)
   localparam int c_NUM_STEPS = 2 * MOD_WIDTH;
   // Counter wide enough to hold c_NUM_STEPS without wrapping
   localparam int c_CNT_W     = $clog2(c_NUM_STEPS + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_NUM_STEPS - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   // State encoding
   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_CALC = 2'd1;
   localparam logic [1:0] c_ST_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;

   KeyType             r_n;      // latched modulus
   KeyType             r_r;      // running remainder, doubles as o_base
   logic [c_CNT_W-1:0] r_cnt;    // doublings performed so far

   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_accept;
   logic               w_step;
   logic               w_last;

   logic [MOD_WIDTH:0] w_dbl;    // 2*r, one bit wider so nothing is lost
   logic               w_ge;
   KeyType             w_sub;
   KeyType             w_r_nxt;

   // -------------------------------------------------------------------------
   // Modular doubling datapath
   // Because r < N on entry, 2r < 2N, so a single conditional subtract
   // brings the result back below N. The subtraction only needs the low
   // MOD_WIDTH bits: when 2r >= N the true difference is < N and fits.
   // -------------------------------------------------------------------------
   assign w_dbl   = {r_r, 1'b0};
   assign w_ge    = (w_dbl >= {1'b0, r_n});
   assign w_sub   = w_dbl[MOD_WIDTH-1:0] - r_n;
   assign w_r_nxt = w_ge ? w_sub : w_dbl[MOD_WIDTH-1:0];

   assign w_last  = (r_cnt == c_CNT_LAST);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (i_valid) begin
               w_state_nxt = c_ST_CALC;
            end
         end
         c_ST_CALC: begin
            // The step taken while cnt holds its last value is the final one
            if (w_last) begin
               w_state_nxt = c_ST_DONE;
            end
         end
         c_ST_DONE: begin
            if (o_ready) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: output / control decode (state only, so no input-to-output path)
   // -------------------------------------------------------------------------
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         c_ST_IDLE: w_in_ready  = 1'b1;
         c_ST_CALC: w_step      = 1'b1;
         c_ST_DONE: w_out_valid = 1'b1;
         default: begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
            w_step      = 1'b0;
         end
      endcase
   end

   assign w_accept = w_in_ready & i_valid;

   // -------------------------------------------------------------------------
   // Datapath registers
   // r_r and r_n are only written on accept or during CALC, so o_base is
   // stable through DONE and keeps its last value in IDLE.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_n   <= '0;
         r_r   <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_n   <= i_modulus;
         r_r   <= KeyType'(1);
         r_cnt <= '0;
      end else if (w_step) begin
         r_r   <= w_r_nxt;
         r_cnt <= r_cnt + c_CNT_ONE;
      end
   end

   assign i_ready = w_in_ready;
   assign o_valid = w_out_valid;
   assign o_base  = r_r;

endmodule : rsa_two_power_mod

`default_nettype wire

// File: tb/tb_rsa_two_power_mod.sv
`default_nettype none

// ============================================================================
//  tb_rsa_two_power_mod
//  Directed self-checking bench for rsa_two_power_mod with hand-computed
//  expected results for 2^512 mod N.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_rsa_two_power_mod;

   localparam int W       = 256;
   localparam int LATENCY = 2 * W + 1;
   localparam int BOUND   = 2000;

   logic         clk;
   logic         clk_en;
   logic         rst;
   logic         i_valid;
   logic         i_ready;
   logic [W-1:0] i_modulus;
   logic         o_valid;
   logic         o_ready;
   logic [W-1:0] o_base;

   int n_vec;
   int n_err;

   rsa_two_power_mod u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .i_modulus (i_modulus),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_base    (o_base)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // Present a modulus at a falling edge, wait (bounded) for i_ready, and
   // return at the falling edge after the accept edge with i_valid dropped.
   task automatic start_job(input logic [W-1:0] n, output bit ok);
      @(negedge clk);
      i_valid   = 1'b1;
      i_modulus = n;
      ok = 1'b0;
      for (int k = 0; k < BOUND; k++) begin
         if (i_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      i_valid   = 1'b0;
      i_modulus = {8{$urandom}};
   endtask

   // Count rising edges from the accept edge (inclusive) until o_valid is
   // seen; lat = -1 if it never comes within the bound.
   task automatic wait_valid(input int start, output int lat);
      lat = start;
      for (int k = 0; k < BOUND; k++) begin
         if (o_valid) return;
         @(negedge clk);
         lat++;
      end
      lat = -1;
   endtask

   task automatic test_reset();
      bit seen;
      clk_en    = 1'b0;
      rst       = 1'b1;
      i_valid   = 1'b0;
      i_modulus = '0;
      o_ready   = 1'b1;
      #3 rst = 1'b0;
      #1;
      n_vec++;
      if (i_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_i_ready: got %b want 1", i_ready);
      end
      n_vec++;
      if (o_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_o_valid: got %b want 0", o_valid);
      end
      n_vec++;
      if (o_base !== '0) begin
         n_err++; $display("FAIL reset_o_base: got %h want 0", o_base);
      end
      #2 clk_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (o_valid !== 1'b0) seen = 1'b1;
      end
      n_vec++;
      if (seen) begin
         n_err++; $display("FAIL reset_idle_o_valid: got 1 want 0");
      end
   endtask

   task automatic test_known();
      logic [W-1:0] mods [6];
      logic [W-1:0] exps [6];
      bit ok;
      int lat;
      mods[0] = W'(3);              exps[0] = W'(1);
      mods[1] = W'(7);              exps[1] = W'(4);
      mods[2] = W'(11);             exps[2] = W'(4);
      mods[3] = {W{1'b1}};          exps[3] = W'(1);
      mods[4] = {1'b1, {(W-2){1'b0}}, 1'b1};
      exps[4] = W'(4);
      mods[5] = W'(13);             exps[5] = W'(9);
      o_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         start_job(mods[i], ok);
         n_vec++;
         if (!ok) begin
            n_err++; $display("FAIL known_accept[%0d]: got no i_ready want i_ready", i);
         end
         wait_valid(1, lat);
         n_vec++;
         if (lat !== LATENCY) begin
            n_err++; $display("FAIL known_latency[%0d]: got %0d want %0d", i, lat, LATENCY);
         end
         n_vec++;
         if (o_base !== exps[i]) begin
            n_err++; $display("FAIL known_base[%0d]: got %h want %h", i, o_base, exps[i]);
         end
         @(posedge clk);
         @(negedge clk);
         n_vec++;
         if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
            n_err++; $display("FAIL known_return_idle[%0d]: got o_valid=%b i_ready=%b want 0 1",
                              i, o_valid, i_ready);
         end
      end
      // o_base keeps the last result while idle
      repeat (3) @(negedge clk);
      n_vec++;
      if (o_base !== W'(9)) begin
         n_err++; $display("FAIL idle_hold_base: got %h want 9", o_base);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      bit bad;
      int lat;
      o_ready = 1'b0;
      start_job(W'(7), ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL bp_accept: got no i_ready want i_ready");
      end
      wait_valid(1, lat);
      n_vec++;
      if (lat !== LATENCY) begin
         n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, LATENCY);
      end
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (o_valid !== 1'b1 || o_base !== W'(4) || i_ready !== 1'b0) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
         n_err++; $display("FAIL bp_hold: got o_valid=%b o_base=%h i_ready=%b want 1 4 0",
                           o_valid, o_base, i_ready);
      end
      o_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_release: got i_ready=%b o_valid=%b want 1 0", i_ready, o_valid);
      end
   endtask

   task automatic test_busy_ignored();
      bit ok;
      int lat;
      o_ready = 1'b1;
      start_job(W'(7), ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL busy_accept: got no i_ready want i_ready");
      end
      // Offer a second job while the first is still calculating
      repeat (50) @(negedge clk);
      i_valid   = 1'b1;
      i_modulus = W'(5);
      wait_valid(51, lat);
      n_vec++;
      if (lat !== LATENCY) begin
         n_err++; $display("FAIL busy_first_latency: got %0d want %0d", lat, LATENCY);
      end
      n_vec++;
      if (o_base !== W'(4)) begin
         n_err++; $display("FAIL busy_first_base: got %h want 4", o_base);
      end
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
         n_err++; $display("FAIL busy_back_idle: got i_ready=%b o_valid=%b want 1 0", i_ready, o_valid);
      end
      // The held request is accepted on this next edge
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      n_vec++;
      if (i_ready !== 1'b0) begin
         n_err++; $display("FAIL busy_second_accept: got i_ready=%b want 0", i_ready);
      end
      wait_valid(1, lat);
      n_vec++;
      if (lat !== LATENCY) begin
         n_err++; $display("FAIL busy_second_latency: got %0d want %0d", lat, LATENCY);
      end
      n_vec++;
      if (o_base !== W'(1)) begin
         n_err++; $display("FAIL busy_second_base: got %h want 1", o_base);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      int lat;
      o_ready = 1'b1;
      start_job(W'(13), ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL rmid_accept: got no i_ready want i_ready");
      end
      repeat (199) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_vec++;
      if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_base !== '0) begin
         n_err++; $display("FAIL rmid_async: got i_ready=%b o_valid=%b o_base=%h want 1 0 0",
                           i_ready, o_valid, o_base);
      end
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (600) begin
         @(negedge clk);
         if (o_valid !== 1'b0) seen = 1'b1;
      end
      n_vec++;
      if (seen) begin
         n_err++; $display("FAIL rmid_no_valid: got 1 want 0");
      end
      start_job(W'(11), ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL rmid_next_accept: got no i_ready want i_ready");
      end
      wait_valid(1, lat);
      n_vec++;
      if (lat !== LATENCY) begin
         n_err++; $display("FAIL rmid_next_latency: got %0d want %0d", lat, LATENCY);
      end
      n_vec++;
      if (o_base !== W'(4)) begin
         n_err++; $display("FAIL rmid_next_base: got %h want 4", o_base);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_known();
      test_backpressure();
      test_busy_ignored();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_rsa_two_power_mod

`default_nettype wire
